conv_result_collector: RTL and testbench

- Sink-side partner of the convolver; consumes its output stream (conv_op, valid_conv, end_conv).
- Requantizes each 32-bit convolution result to OUT_W bits and buffers one full output feature map of M*M results, where M = (N-K)/S+1.
- Replays the buffered map row-major over a valid/ready read port toward the next layer or writeback.
- The convolver has no backpressure, so this block absorbs its burst and applies flow control only on the read side.

---
 rtl/conv_result_collector.sv | 126 ++++++++++++
 tb/tb_conv_result_collector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// Collects one convolver output map, requantizes each result to OUT_W bits,
// and replays the buffered map row-major over a valid/ready read port.
module conv_result_collector #(
   parameter int N     = 4,
   parameter int K     = 3,
   parameter int S     = 1,
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  conv_op,
   input  logic                    valid_conv,
   input  logic                    end_conv,
   input  logic                    rd_ready,
   output logic                    rd_valid,
   output logic signed [OUT_W-1:0] rd_data,
   output logic                    rd_last,
   output logic                    frame_done,
   output logic                    overflow,
   output logic                    short_frame
);

   localparam int M     = (N - K) / S + 1;
   localparam int DEPTH = M * M;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                  state, state_d;
   logic [CNT_W-1:0]        wr_cnt, wr_next, count;
   logic [IDX_W-1:0]        rd_idx;
   logic signed [OUT_W-1:0] mem [DEPTH];
   logic                    capture, close, short_set, ovf_set, advance, finish, last;

   function automatic logic signed [OUT_W-1:0] requant(input logic signed [IN_W-1:0] x);
      logic signed [IN_W-1:0] q;
      q = x >>> SHIFT;
      if (q > MAX_V)
         return {1'b0, {(OUT_W-1){1'b1}}};
      else if (q < MIN_V)
         return {1'b1, {(OUT_W-1){1'b0}}};
      else
         return q[OUT_W-1:0];
   endfunction

   assign last     = (state == DRAIN) && (CNT_W'(rd_idx) == count - CNT_W'(1));
   assign rd_valid = (state == DRAIN);
   assign rd_last  = last;
   assign rd_data  = (state == DRAIN) ? mem[rd_idx] : '0;

   always_comb begin
      state_d   = state;
      capture   = 1'b0;
      close     = 1'b0;
      short_set = 1'b0;
      ovf_set   = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      wr_next   = wr_cnt + CNT_W'(valid_conv);
      case (state)
         COLLECT: begin
            capture = valid_conv;
            // A coincident end_conv closes the frame including this cycle's write.
            if ((wr_next == CNT_W'(DEPTH)) || end_conv) begin
               if (wr_next == '0) begin
                  short_set = 1'b1;
               end else begin
                  state_d   = DRAIN;
                  close     = 1'b1;
                  short_set = (wr_next != CNT_W'(DEPTH));
               end
            end
         end
         DRAIN: begin
            ovf_set = valid_conv;
            if (rd_ready) begin
               if (last) begin
                  state_d = COLLECT;
                  finish  = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= COLLECT;
         wr_cnt      <= '0;
         count       <= '0;
         rd_idx      <= '0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         state      <= state_d;
         frame_done <= finish;
         if (ovf_set)   overflow    <= 1'b1;
         if (short_set) short_frame <= 1'b1;
         if (close)     count       <= wr_next;
         if (finish) begin
            wr_cnt <= '0;
            rd_idx <= '0;
         end else begin
            if (capture) wr_cnt <= wr_next;
            if (advance) rd_idx <= rd_idx + IDX_W'(1);
         end
      end
   end

   // Result storage carries no reset; contents only matter once captured.
   always_ff @(posedge clk) begin
      if (capture)
         mem[wr_cnt[IDX_W-1:0]] <= requant(conv_op);
   end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector with a queue-based scoreboard;
// a second instance with SHIFT=4 shares all inputs.
module tb_conv_result_collector;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [31:0] conv_op;
   logic               valid_conv, end_conv, rd_ready;
   logic               rd_valid, rd_last, frame_done, overflow, short_frame;
   logic signed [15:0] rd_data;
   logic               rd_valid4, rd_last4, frame_done4, overflow4, short_frame4;
   logic signed [15:0] rd_data4;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] d0;
      logic [15:0] d4;
      logic        chk4;
      logic        last;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   conv_result_collector #(.N(4), .K(3), .S(1), .IN_W(32), .OUT_W(16), .SHIFT(0)) dut (
      .clk(clk), .rst(rst), .conv_op(conv_op), .valid_conv(valid_conv), .end_conv(end_conv),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .frame_done(frame_done), .overflow(overflow), .short_frame(short_frame)
   );

   conv_result_collector #(.N(4), .K(3), .S(1), .IN_W(32), .OUT_W(16), .SHIFT(4)) dut4 (
      .clk(clk), .rst(rst), .conv_op(conv_op), .valid_conv(valid_conv), .end_conv(end_conv),
      .rd_ready(rd_ready), .rd_valid(rd_valid4), .rd_data(rd_data4), .rd_last(rd_last4),
      .frame_done(frame_done4), .overflow(overflow4), .short_frame(short_frame4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input logic e, input logic [15:0] x0,
                       input logic [15:0] x4, input logic c4, input logic lst);
      exp_t ent;
      conv_op    = v;
      valid_conv = 1'b1;
      end_conv   = e;
      ent.d0 = x0; ent.d4 = x4; ent.chk4 = c4; ent.last = lst;
      exp_q.push_back(ent);
      step();
      valid_conv = 1'b0;
      end_conv   = 1'b0;
   endtask

   task automatic send_n(input logic [31:0] v, input logic e, input logic lst);
      send(v, e, v[15:0], 16'h0, 1'b0, lst);
   endtask

   task automatic read_frame(input logic [7:0] pat, input int plen);
      exp_t ent;
      int   cyc = 0;
      logic done = 1'b0;
      while (exp_q.size() > 0 && cyc < 64) begin
         ent      = exp_q[0];
         rd_ready = pat[cyc % plen];
         check("rd_valid", {31'b0, rd_valid}, 32'd1);
         check("rd_data", {16'b0, $unsigned(rd_data)}, {16'b0, ent.d0});
         check("rd_last", {31'b0, rd_last}, {31'b0, ent.last});
         check("frame_done_low", {31'b0, frame_done}, 32'd0);
         if (ent.chk4)
            check("rd_data_shift4", {16'b0, $unsigned(rd_data4)}, {16'b0, ent.d4});
         step();
         cyc++;
         if (rd_ready) begin
            void'(exp_q.pop_front());
            done = ent.last;
         end
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      rd_ready = 1'b0;
      check("frame_done_pulse", {31'b0, frame_done}, {31'b0, done});
      check("rd_valid_after", {31'b0, rd_valid}, 32'd0);
      step();
      check("frame_done_once", {31'b0, frame_done}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; conv_op = '0; valid_conv = 1'b0; end_conv = 1'b0; rd_ready = 1'b0;
      #2 rst = 1'b0;

      // 1: reset holds all outputs low regardless of inputs
      for (int i = 0; i < 3; i++) begin
         conv_op    = $urandom;
         valid_conv = 1'($urandom_range(0, 1));
         end_conv   = 1'($urandom_range(0, 1));
         rd_ready   = 1'($urandom_range(0, 1));
         step();
         check("rst_outputs", {26'b0, rd_valid, rd_last, frame_done, overflow, short_frame,
                               |rd_data}, 32'd0);
      end
      conv_op = '0; valid_conv = 1'b0; end_conv = 1'b0; rd_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      check("idle_rd_valid", {31'b0, rd_valid}, 32'd0);

      // 2: nominal frame
      rd_ready = 1'b1;
      send_n(32'd10, 1'b0, 1'b0);
      send_n(32'd20, 1'b0, 1'b0);
      send_n(32'd30, 1'b0, 1'b0);
      check("no_valid_before_fill", {31'b0, rd_valid}, 32'd0);
      send_n(32'd40, 1'b1, 1'b1);
      read_frame(8'hFF, 1);
      check("nominal_overflow", {31'b0, overflow}, 32'd0);
      check("nominal_short", {31'b0, short_frame}, 32'd0);

      // 4: backpressure pattern 0,1,0,0,1,1,0,1
      send_n(32'd1, 1'b0, 1'b0);
      send_n(32'd2, 1'b0, 1'b0);
      send_n(32'd3, 1'b0, 1'b0);
      send_n(32'd4, 1'b0, 1'b1);
      read_frame(8'b1011_0010, 8);

      // 5a: write during drain is dropped and flags overflow
      send_n(32'd1, 1'b0, 1'b0);
      send_n(32'd2, 1'b0, 1'b0);
      send_n(32'd3, 1'b0, 1'b0);
      send_n(32'd4, 1'b0, 1'b1);
      conv_op = 32'd99; valid_conv = 1'b1; rd_ready = 1'b0;
      step();
      valid_conv = 1'b0;
      check("overflow_set", {31'b0, overflow}, 32'd1);
      read_frame(8'hFF, 1);

      // 5b: short frame of two results
      send_n(32'd5, 1'b0, 1'b0);
      check("short_not_yet", {31'b0, short_frame}, 32'd0);
      send_n(32'd6, 1'b1, 1'b1);
      check("short_set", {31'b0, short_frame}, 32'd1);
      read_frame(8'hFF, 1);
      check("overflow_sticky", {31'b0, overflow}, 32'd1);

      // 3: saturation and shift (both instances)
      send(32'h0001_0000, 1'b0, 16'h7FFF, 16'h1000, 1'b1, 1'b0);
      send(32'hFFFF_0000, 1'b0, 16'h8000, 16'hF000, 1'b1, 1'b0);
      send(32'hFFFF_FFFB, 1'b0, 16'hFFFB, 16'hFFFF, 1'b1, 1'b0);
      send(32'h0000_0123, 1'b0, 16'h0123, 16'h0012, 1'b1, 1'b1);
      read_frame(8'hFF, 1);
      send(32'hFFFF_FFF0, 1'b1, 16'hFFF0, 16'hFFFF, 1'b1, 1'b1);
      read_frame(8'hFF, 1);

      // 6: reset in the middle of a drain
      send_n(32'd7, 1'b0, 1'b0);
      send_n(32'd8, 1'b0, 1'b0);
      send_n(32'd9, 1'b0, 1'b0);
      send_n(32'd10, 1'b0, 1'b1);
      rd_ready = 1'b1;
      check("mid_data0", {16'b0, $unsigned(rd_data)}, 32'd7);
      step();
      check("mid_data1", {16'b0, $unsigned(rd_data)}, 32'd8);
      step();
      check("mid_data2", {16'b0, $unsigned(rd_data)}, 32'd9);
      rst = 1'b0;
      #1;
      check("async_rst_outputs", {26'b0, rd_valid, rd_last, frame_done, overflow, short_frame,
                                  |rd_data}, 32'd0);
      exp_q.delete();
      rd_ready = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("post_rst_idle", {31'b0, rd_valid}, 32'd0);

      end_conv = 1'b1;
      step();
      end_conv = 1'b0;
      check("empty_end_short", {31'b0, short_frame}, 32'd1);
      check("empty_end_no_drain", {31'b0, rd_valid}, 32'd0);
      step();
      check("empty_end_no_done", {31'b0, frame_done}, 32'd0);

      send_n(32'd11, 1'b0, 1'b0);
      send_n(32'd12, 1'b0, 1'b0);
      send_n(32'd13, 1'b0, 1'b0);
      send_n(32'd14, 1'b0, 1'b1);
      read_frame(8'hFF, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
